// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter in front of a single memory port. The
//            instruction-fetch unit (read-only) and the load/store unit
//            (read or write) share the memory with exactly one transaction
//            outstanding at a time. A response is routed only to the
//            requester that owns the transaction.
// Ports    : clk, rst (async, active-low)
//            ifu_req_valid/ready, ifu_addr        : IFU fetch request
//            ifu_resp_valid, ifu_rdata            : IFU fetch response
//            lsu_req_valid/ready, lsu_wen/addr/len/wdata : LSU request
//            lsu_resp_valid, lsu_rdata            : LSU load data / store ack
//            mem_req_valid/ready, mem_wen/addr/len/wdata : memory request
//            mem_resp_valid, mem_rdata            : memory response
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [2:0]            lsu_len,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_len,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  state_t state;
  logic   owner;
  logic   last_grant;

  logic   win_lsu;
  logic   win_ifu;
  logic   idle_open;
  logic   resp_fire;

  // Round robin: on a tie the requester that was not granted last wins.
  assign win_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == GNT_IFU));
  assign win_ifu = ifu_req_valid && !win_lsu;

  // The reset input is folded in so the readies drop immediately while
  // reset is held, even though the state register already reads IDLE.
  assign idle_open     = rst && (state == S_IDLE);
  assign ifu_req_ready = idle_open && win_ifu;
  assign lsu_req_ready = idle_open && win_lsu;

  assign mem_req_valid = (state == S_ISSUE);

  // Responses outside WAIT are stale and never reach a requester.
  assign resp_fire      = (state == S_WAIT) && mem_resp_valid;
  assign ifu_resp_valid = resp_fire && (owner == GNT_IFU);
  assign lsu_resp_valid = resp_fire && (owner == GNT_LSU);
  assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  // A store acknowledge carries no data.
  assign lsu_rdata      = (lsu_resp_valid && !mem_wen) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= GNT_IFU;
      last_grant <= GNT_IFU;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_len    <= 3'd0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_req_ready) begin
            state      <= S_ISSUE;
            owner      <= GNT_LSU;
            last_grant <= GNT_LSU;
            mem_wen    <= lsu_wen;
            mem_addr   <= lsu_addr;
            mem_len    <= lsu_len;
            mem_wdata  <= lsu_wdata;
          end else if (ifu_req_ready) begin
            state      <= S_ISSUE;
            owner      <= GNT_IFU;
            last_grant <= GNT_IFU;
            mem_wen    <= 1'b0;
            mem_addr   <= ifu_addr;
            mem_len    <= 3'd4;
            mem_wdata  <= '0;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
